// File: rtl/data_mem_responder.sv
// Data-memory responder for the pipeline load/store port: one word/byte access at a time,
// WAIT_CYCLES wait states, single-cycle response pulse with fault reporting.
module data_mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IW         = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT   = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_wr;
    logic        r_byte;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_res_err;
    logic [31:0] r_res_data;
    logic [31:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_commit;
    logic        w_wr;
    logic        w_byte;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [1:0]  w_lane;
    logic [IW-1:0] w_idx;
    logic [31:0] w_word;
    logic        w_err;
    logic [31:0] w_rdata;

    assign req_ready = rst_n & (r_state == S_IDLE);
    assign w_accept  = req_valid & req_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt == 4'd0) w_state_nxt = S_RESP;
            S_RESP: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states the commit edge is the accept edge, so the live request is used.
    assign w_commit = (w_state_nxt == S_RESP) && (r_state != S_RESP);
    assign w_wr     = (r_state == S_IDLE) ? req_wr    : r_wr;
    assign w_byte   = (r_state == S_IDLE) ? req_byte  : r_byte;
    assign w_addr   = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_wdata  = (r_state == S_IDLE) ? req_wdata : r_wdata;

    assign w_lane = w_addr[1:0];
    assign w_idx  = w_addr[IW+1:2];
    assign w_word = r_mem[w_idx];
    assign w_err  = (w_addr >= ADDR_LIMIT) || (!w_byte && (w_lane != 2'd0));

    always_comb begin
        w_rdata = '0;
        if (!w_err && !w_wr) begin
            if (w_byte) w_rdata = {24'd0, w_word[{w_lane, 3'b000} +: 8]};
            else        w_rdata = w_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_wr       <= 1'b0;
            r_byte     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_res_err  <= 1'b0;
            r_res_data <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_wr    <= req_wr;
                r_byte  <= req_byte;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= CNT_INIT;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_res_err  <= w_err;
                r_res_data <= w_rdata;
            end
            rsp_valid <= (r_state == S_RESP);
            rsp_rdata <= (r_state == S_RESP) ? r_res_data : '0;
            rsp_err   <= (r_state == S_RESP) ? r_res_err  : 1'b0;
        end
    end

    // Array is deliberately not reset; reset holds the FSM in IDLE so no commit can occur.
    always_ff @(posedge clk) begin
        if (w_commit && w_wr && !w_err) begin
            if (w_byte) r_mem[w_idx][{w_lane, 3'b000} +: 8] <= w_wdata[{w_lane, 3'b000} +: 8];
            else        r_mem[w_idx] <= w_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (1, 0 and 15 wait states)
// share request wires; sel picks which one receives req_valid and is observed.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_wr;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  sel;

    logic [2:0]  vin;
    logic [2:0]  rdy;
    logic [2:0]  vld;
    logic [2:0]  er;
    logic [31:0] rd [3];

    logic        d_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rdata;
    logic        d_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign vin[0] = req_valid & (sel == 2'd0);
    assign vin[1] = req_valid & (sel == 2'd1);
    assign vin[2] = req_valid & (sel == 2'd2);

    always_comb begin
        d_ready     = rdy[sel];
        d_rsp_valid = vld[sel];
        d_rdata     = rd[sel];
        d_err       = er[sel];
    end

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(vin[0]), .req_ready(rdy[0]),
        .req_wr(req_wr), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld[0]), .rsp_rdata(rd[0]), .rsp_err(er[0])
    );

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n), .req_valid(vin[1]), .req_ready(rdy[1]),
        .req_wr(req_wr), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld[1]), .rsp_rdata(rd[1]), .rsp_err(er[1])
    );

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(15)) u_dut_w15 (
        .clk(clk), .rst_n(rst_n), .req_valid(vin[2]), .req_ready(rdy[2]),
        .req_wr(req_wr), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld[2]), .rsp_rdata(rd[2]), .rsp_err(er[2])
    );

    // Issues one request to the selected instance; lat counts edges after the accept edge.
    task automatic access(input logic wr, input logic byt, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
        int n;
        rdata = '0;
        err   = 1'b0;
        lat   = -1;
        @(negedge clk);
        n = 0;
        while (!d_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_wr    = wr;
        req_byte  = byt;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (d_rsp_valid) begin
                lat   = c;
                rdata = d_rdata;
                err   = d_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          seen;
        sel = 2'd0;
        #2;
        checks++; if (rdy !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", rdy); end
        checks++; if (vld !== 3'b000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=000", vld); end
        checks++; if (d_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", d_rdata); end
        checks++; if (d_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", d_err); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rdy !== 3'b111) begin failures++; $display("FAIL ready_after_release got=%b exp=111", rdy); end

        access(1'b1, 1'b0, 32'h10, 32'h12345678, rdata, err, lat);
        checks++; if (lat !== 2 || err !== 1'b0) begin failures++; $display("FAIL reset_prestore lat=%0d err=%b exp lat=2 err=0", lat, err); end

        // abort a store while it sits in WAIT
        @(negedge clk);
        req_wr = 1'b1; req_byte = 1'b0; req_addr = 32'h10; req_wdata = 32'h99999999;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (d_ready !== 1'b0 || d_rsp_valid !== 1'b0) begin failures++; $display("FAIL midwait_reset ready=%b rsp_valid=%b exp 0 0", d_ready, d_rsp_valid); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        @(posedge clk);
        #1;
        checks++; if (d_ready !== 1'b1) begin failures++; $display("FAIL midwait_ready_after got=%b exp=1", d_ready); end
        for (int c = 0; c < 5; c++) begin
            if (d_rsp_valid) seen++;
            @(posedge clk);
            #1;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midwait_no_rsp got=%0d exp=0", seen); end
        access(1'b0, 1'b0, 32'h10, 32'h0, rdata, err, lat);
        checks++; if (rdata !== 32'h12345678 || err !== 1'b0) begin failures++; $display("FAIL midwait_mem_unchanged got=%h err=%b exp=12345678 err=0", rdata, err); end
    endtask

    task automatic test_word();
        logic [31:0] rdata;
        logic        err;
        int          lat;
        sel = 2'd0;
        access(1'b1, 1'b0, 32'h20, 32'hDEADBEEF, rdata, err, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL str_latency got=%0d exp=2", lat); end
        checks++; if (rdata !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL str_rsp got=%h err=%b exp=0 err=0", rdata, err); end
        access(1'b0, 1'b0, 32'h20, 32'h0, rdata, err, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL ldr_latency got=%0d exp=2", lat); end
        checks++; if (rdata !== 32'hDEADBEEF || err !== 1'b0) begin failures++; $display("FAIL ldr_data got=%h err=%b exp=deadbeef err=0", rdata, err); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rdata;
        logic        err;
        int          lat;
        sel = 2'd0;
        access(1'b1, 1'b0, 32'h40, 32'h11223344, rdata, err, lat);
        access(1'b1, 1'b1, 32'h42, 32'hAAAAAAAA, rdata, err, lat);
        checks++; if (err !== 1'b0 || rdata !== 32'h0) begin failures++; $display("FAIL strb_rsp got=%h err=%b exp=0 err=0", rdata, err); end
        access(1'b0, 1'b0, 32'h40, 32'h0, rdata, err, lat);
        checks++; if (rdata !== 32'h11AA3344) begin failures++; $display("FAIL strb_merge got=%h exp=11aa3344", rdata); end
        access(1'b0, 1'b1, 32'h43, 32'h0, rdata, err, lat);
        checks++; if (rdata !== 32'h00000011 || err !== 1'b0) begin failures++; $display("FAIL ldrb_lane3 got=%h err=%b exp=00000011", rdata, err); end
        access(1'b0, 1'b1, 32'h40, 32'h0, rdata, err, lat);
        checks++; if (rdata !== 32'h00000044) begin failures++; $display("FAIL ldrb_lane0 got=%h exp=00000044", rdata); end
    endtask

    task automatic test_faults();
        logic [31:0] rdata;
        logic        err;
        int          lat;
        sel = 2'd0;
        access(1'b0, 1'b0, 32'h41, 32'h0, rdata, err, lat);
        checks++; if (err !== 1'b1 || rdata !== 32'h0) begin failures++; $display("FAIL ldr_misaligned got=%h err=%b exp=0 err=1", rdata, err); end
        access(1'b0, 1'b0, 32'h400, 32'h0, rdata, err, lat);
        checks++; if (err !== 1'b1 || rdata !== 32'h0 || lat !== 2) begin failures++; $display("FAIL ldr_out_of_range got=%h err=%b lat=%0d exp=0 err=1 lat=2", rdata, err, lat); end
        access(1'b1, 1'b0, 32'h42, 32'hFFFFFFFF, rdata, err, lat);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL str_misaligned_err got=%b exp=1", err); end
        access(1'b1, 1'b0, 32'h400, 32'hFFFFFFFF, rdata, err, lat);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL str_out_of_range_err got=%b exp=1", err); end
        access(1'b0, 1'b0, 32'h40, 32'h0, rdata, err, lat);
        checks++; if (rdata !== 32'h11AA3344 || err !== 1'b0) begin failures++; $display("FAIL fault_mem_unchanged got=%h err=%b exp=11aa3344", rdata, err); end
        access(1'b0, 1'b0, 32'h0, 32'h0, rdata, err, lat);
        checks++; if (rdata === 32'hFFFFFFFF) begin failures++; $display("FAIL oob_store_aliased got=%h exp!=ffffffff", rdata); end
        access(1'b1, 1'b1, 32'h3FF, 32'h5A5A5A5A, rdata, err, lat);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL strb_last_byte_err got=%b exp=0", err); end
        access(1'b0, 1'b1, 32'h3FF, 32'h0, rdata, err, lat);
        checks++; if (rdata !== 32'h0000005A || err !== 1'b0) begin failures++; $display("FAIL ldrb_last_byte got=%h err=%b exp=0000005a", rdata, err); end
    endtask

    task automatic test_stall();
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          low;
        int          nrsp;
        logic [31:0] got;
        sel  = 2'd0;
        low  = 0;
        nrsp = 0;
        got  = '0;
        @(negedge clk);
        req_wr = 1'b0; req_byte = 1'b0; req_addr = 32'h20; req_wdata = 32'h0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!d_ready) low++;
        // keep a hostile store request asserted while the load is in flight
        req_wr = 1'b1; req_addr = 32'h40; req_wdata = 32'h0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (d_rsp_valid) begin
                nrsp++;
                got = d_rdata;
                req_valid = 1'b0;
                break;
            end
            if (!d_ready) low++;
            req_addr = req_addr ^ 32'h4;
        end
        req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (d_rsp_valid) nrsp++;
        end
        checks++; if (nrsp !== 1) begin failures++; $display("FAIL stall_rsp_count got=%0d exp=1", nrsp); end
        checks++; if (got !== 32'hDEADBEEF) begin failures++; $display("FAIL stall_data got=%h exp=deadbeef", got); end
        checks++; if (low !== 2) begin failures++; $display("FAIL stall_ready_low got=%0d exp=2", low); end
        access(1'b0, 1'b0, 32'h40, 32'h0, rdata, err, lat);
        checks++; if (rdata !== 32'h11AA3344) begin failures++; $display("FAIL stall_no_extra_write got=%h exp=11aa3344", rdata); end
    endtask

    task automatic test_params();
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          sp;
        int          nr;
        int          cyc;
        int          tcyc [3];
        logic [31:0] got  [3];
        logic [31:0] va;
        for (int k = 1; k <= 2; k++) begin
            sel = 2'(k);
            sp  = (k == 1) ? 2 : 17;
            va  = 32'hA5A50000 | 32'(k);
            access(1'b1, 1'b0, 32'h0, va, rdata, err, lat);
            checks++; if (lat !== sp - 1) begin failures++; $display("FAIL param%0d_latency got=%0d exp=%0d", k, lat, sp - 1); end
            access(1'b1, 1'b0, 32'h3FC, 32'h0000BEEF, rdata, err, lat);
            nr  = 0;
            cyc = 0;
            for (int i = 0; i < 3; i++) begin tcyc[i] = 0; got[i] = '0; end
            @(negedge clk);
            req_wr = 1'b0; req_byte = 1'b0; req_addr = 32'h0; req_valid = 1'b1;
            while (nr < 3 && cyc < 100) begin
                @(posedge clk);
                #1;
                cyc++;
                if (d_rsp_valid) begin
                    tcyc[nr] = cyc;
                    got[nr]  = d_rdata;
                    nr++;
                    req_addr = (nr == 1) ? 32'h3FC : 32'h0;
                    if (nr == 3) req_valid = 1'b0;
                end
            end
            req_valid = 1'b0;
            checks++; if (nr !== 3) begin failures++; $display("FAIL param%0d_rsp_count got=%0d exp=3", k, nr); end
            checks++; if (got[0] !== va || got[1] !== 32'h0000BEEF || got[2] !== va) begin failures++; $display("FAIL param%0d_data got=%h %h %h exp=%h 0000beef %h", k, got[0], got[1], got[2], va, va); end
            checks++; if (tcyc[1] - tcyc[0] !== sp || tcyc[2] - tcyc[1] !== sp) begin failures++; $display("FAIL param%0d_spacing got=%0d %0d exp=%0d", k, tcyc[1] - tcyc[0], tcyc[2] - tcyc[1], sp); end
        end
        sel = 2'd0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        sel       = 2'd0;
        test_reset();
        test_word();
        test_byte_lanes();
        test_faults();
        test_stall();
        test_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end

endmodule
